// File: rtl/key_count_blinker.sv
// key_count_blinker
// Shows a captured press count on an LED as that many discrete blinks,
// followed by a quiet gap, then pulses done for one cycle.
//
// Ports:
//   clk      system clock
//   rst_n    synchronous reset, active HIGH despite the name
//   start    single-cycle request to display count (honoured only when idle)
//   count    number of blinks, captured on an accepted start
//   busy     high while a sequence (blinks + gap) is in progress
//   led_out  LED drive, high only during the ON phase of a blink
//   done     one-cycle pulse in the first idle cycle after the gap
module key_count_blinker #(
    parameter int unsigned ON_TICKS  = 12_500_000,
    parameter int unsigned OFF_TICKS = 12_500_000,
    parameter int unsigned GAP_TICKS = 50_000_000,
    parameter int unsigned CNT_W     = 3,
    parameter int unsigned TMR_W     = 26
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] count,
    output logic             busy,
    output logic             led_out,
    output logic             done
);

    // Terminal timer values for each timed phase
    localparam logic [TMR_W-1:0] ON_LAST  = TMR_W'(ON_TICKS - 1);
    localparam logic [TMR_W-1:0] OFF_LAST = TMR_W'(OFF_TICKS - 1);
    localparam logic [TMR_W-1:0] GAP_LAST = TMR_W'(GAP_TICKS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ON   = 2'd1,
        S_OFF  = 2'd2,
        S_GAP  = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [TMR_W-1:0] r_timer;
    logic [TMR_W-1:0] w_timer_nxt;
    logic [CNT_W-1:0] r_remaining;
    logic [CNT_W-1:0] w_remaining_nxt;
    logic             w_done_nxt;
    logic             r_busy;
    logic             r_led;
    logic             r_done;

    // Next-state, timer and blink-count logic
    always_comb begin
        w_state_nxt     = r_state;
        w_timer_nxt     = r_timer + TMR_W'(1);
        w_remaining_nxt = r_remaining;
        w_done_nxt      = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_timer_nxt = '0;
                if (start) begin
                    w_remaining_nxt = count;
                    w_state_nxt     = (count != '0) ? S_ON : S_GAP;
                end
            end
            S_ON: begin
                if (r_timer == ON_LAST) begin
                    w_timer_nxt = '0;
                    w_state_nxt = S_OFF;
                end
            end
            S_OFF: begin
                if (r_timer == OFF_LAST) begin
                    w_timer_nxt     = '0;
                    // Only reached with remaining >= 1, so this never wraps
                    w_remaining_nxt = r_remaining - CNT_W'(1);
                    w_state_nxt     = (r_remaining == CNT_W'(1)) ? S_GAP : S_ON;
                end
            end
            S_GAP: begin
                if (r_timer == GAP_LAST) begin
                    w_timer_nxt = '0;
                    w_state_nxt = S_IDLE;
                    w_done_nxt  = 1'b1;
                end
            end
            default: begin
                w_timer_nxt = '0;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State register plus registered Moore outputs decoded from next state
    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_state     <= S_IDLE;
            r_timer     <= '0;
            r_remaining <= '0;
            r_busy      <= 1'b0;
            r_led       <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_timer     <= w_timer_nxt;
            r_remaining <= w_remaining_nxt;
            r_busy      <= (w_state_nxt != S_IDLE);
            r_led       <= (w_state_nxt == S_ON);
            r_done      <= w_done_nxt;
        end
    end

    assign busy    = r_busy;
    assign led_out = r_led;
    assign done    = r_done;

endmodule

// File: tb/tb_key_count_blinker.sv
// Testbench for key_count_blinker with short timing parameters.
// Expected per-cycle {led_out, busy, done} values are derived from the
// documented latency formulas, queued at stimulus time and popped per cycle.
module tb_key_count_blinker;

    localparam int ON_T  = 3;
    localparam int OFF_T = 2;
    localparam int GAP_T = 4;
    localparam int PER   = ON_T + OFF_T;

    typedef struct packed {
        logic led;
        logic busy;
        logic done;
    } obs_t;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [2:0] count;
    logic       busy;
    logic       led_out;
    logic       done;

    int checks   = 0;
    int failures = 0;
    obs_t exp_q[$];

    key_count_blinker #(
        .ON_TICKS (ON_T),
        .OFF_TICKS(OFF_T),
        .GAP_TICKS(GAP_T),
        .CNT_W    (3),
        .TMR_W    (26)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .count  (count),
        .busy   (busy),
        .led_out(led_out),
        .done   (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Outputs rel cycles after the edge that accepted a start with count n
    function automatic obs_t exp_at(int rel, int n);
        obs_t o;
        o.busy = (rel >= 1) && (rel <= n * PER + GAP_T);
        o.led  = (rel >= 1) && (rel <= n * PER) && (((rel - 1) % PER) < ON_T);
        o.done = (rel == n * PER + GAP_T + 1);
        return o;
    endfunction

    task automatic test_reset();
        obs_t a;
        obs_t e;
        for (int r = 1; r <= 5; r++) exp_q.push_back(obs_t'(3'b000));
        for (int r = 1; r <= 5; r++) begin
            rst_n = (r <= 2);
            start = (r <= 2);
            count = 3'd5;
            @(posedge clk); #1;
            a = {led_out, busy, done};
            e = exp_q.pop_front();
            checks++;
            if (a !== e) begin
                failures++;
                $display("FAIL reset cyc=%0d got led/busy/done=%b want=%b", r, a, e);
            end
        end
        start = 1'b0;
    endtask

    task automatic test_blink(string name, int n);
        obs_t a;
        obs_t e;
        int len;
        len = n * PER + GAP_T + 3;
        for (int r = 1; r <= len; r++) exp_q.push_back(exp_at(r, n));
        for (int r = 1; r <= len; r++) begin
            start = (r == 1);
            count = 3'(n);
            @(posedge clk); #1;
            a = {led_out, busy, done};
            e = exp_q.pop_front();
            checks++;
            if (a !== e) begin
                failures++;
                $display("FAIL %s rel=%0d got led/busy/done=%b want=%b", name, r, a, e);
            end
        end
        start = 1'b0;
    endtask

    task automatic test_count_max();
        obs_t a;
        obs_t e;
        int rises;
        int bw;
        int dones;
        logic prev_led;
        rises = 0; bw = 0; dones = 0; prev_led = 1'b0;
        for (int r = 1; r <= 42; r++) exp_q.push_back(exp_at(r, 7));
        for (int r = 1; r <= 42; r++) begin
            start = (r == 1);
            count = 3'd7;
            @(posedge clk); #1;
            a = {led_out, busy, done};
            e = exp_q.pop_front();
            checks++;
            if (a !== e) begin
                failures++;
                $display("FAIL count7 rel=%0d got led/busy/done=%b want=%b", r, a, e);
            end
            if (led_out && !prev_led) rises++;
            prev_led = led_out;
            if (busy) bw++;
            if (done) dones++;
        end
        start = 1'b0;
        checks++;
        if (rises !== 7) begin
            failures++;
            $display("FAIL count7_rises got=%0d want=7", rises);
        end
        checks++;
        if (bw !== 39) begin
            failures++;
            $display("FAIL count7_busy_width got=%0d want=39", bw);
        end
        checks++;
        if (dones !== 1) begin
            failures++;
            $display("FAIL count7_done_pulses got=%0d want=1", dones);
        end
    endtask

    // Starts during busy are ignored; a start in the done cycle is accepted
    task automatic test_back_to_back();
        obs_t a;
        obs_t e;
        for (int r = 1; r <= 31; r++)
            exp_q.push_back((r <= 20) ? exp_at(r, 3) : exp_at(r - 20, 1));
        for (int r = 1; r <= 31; r++) begin
            start = (r == 1) || (r == 3) || (r == 9) || (r == 21);
            count = (r == 1) ? 3'd3 : 3'd1;
            @(posedge clk); #1;
            a = {led_out, busy, done};
            e = exp_q.pop_front();
            checks++;
            if (a !== e) begin
                failures++;
                $display("FAIL back_to_back rel=%0d got led/busy/done=%b want=%b", r, a, e);
            end
        end
        start = 1'b0;
    endtask

    // Reset during the second ON cycle of blink 2 aborts without done
    task automatic test_reset_mid();
        obs_t a;
        obs_t e;
        for (int r = 1; r <= 20; r++)
            exp_q.push_back((r <= 7) ? exp_at(r, 4) : obs_t'(3'b000));
        for (int r = 1; r <= 20; r++) begin
            start = (r == 1);
            count = 3'd4;
            rst_n = (r == 8);
            @(posedge clk); #1;
            a = {led_out, busy, done};
            e = exp_q.pop_front();
            checks++;
            if (a !== e) begin
                failures++;
                $display("FAIL reset_mid rel=%0d got led/busy/done=%b want=%b", r, a, e);
            end
        end
        rst_n = 1'b0;
        start = 1'b0;
    endtask

    initial begin
        rst_n = 1'b1;
        start = 1'b0;
        count = 3'd0;
        test_reset();
        test_blink("count2", 2);
        test_blink("count0", 0);
        test_count_max();
        test_back_to_back();
        test_reset_mid();
        test_blink("after_reset_count1", 1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/key_count_blinker.md
Name: key_count_blinker

Overview:
- Output-side counterpart to the debounced key-press counter.
- Takes a captured 3-bit press count and reports it on an LED as that many discrete blinks, followed by a mandatory inter-group gap.
- Sits between the press-count register and the board LED pin so an operator can read the count visually.
- Timing is built from cycle counters on the 50 MHz system clock, in the same timebase as the 20 ms debounce window.

Parameters:
- ON_TICKS, 12_500_000, LED-on duration per blink in clk cycles (250 ms at 50 MHz); must be >= 1.
- OFF_TICKS, 12_500_000, LED-off duration after each blink in clk cycles; must be >= 1.
- GAP_TICKS, 50_000_000, quiet period after the last blink, before done, in clk cycles (1 s); must be >= 1.
- CNT_W, 3, width of the count input.
- TMR_W, 26, timer width; must hold max(ON_TICKS, OFF_TICKS, GAP_TICKS) - 1.

Ports:
- clk  input  1  system clock, 50 MHz.
- rst_n  input  1  synchronous, active-high reset. Sampled on the rising edge of clk; a 1 resets the block. The polarity is fixed despite the port name.
- start  input  1  request to display count; single-cycle pulse, sampled only in IDLE.
- count  input  CNT_W  number of blinks to emit; captured on an accepted start.
- busy  output  1  high from the cycle after an accepted start through the last GAP cycle.
- led_out  output  1  LED drive, active-high; 1 only in the ON state.
- done  output  1  single-cycle pulse marking completion of a sequence.

Behaviour:
- Reset (rst_n=1 at a clk edge) forces the following next cycle, regardless of the current state:
  - state=IDLE, timer=0, remaining=0;
  - busy=0, led_out=0, done=0.
- Reset mid-sequence aborts immediately. There is no done pulse and no further blinks.
- States are IDLE, ON, OFF, GAP. All outputs are registered (Moore): led_out=(state==ON), busy=(state!=IDLE).
- IDLE:
  - done=0 except in the single return cycle described under GAP.
  - If start=1: capture remaining<=count and timer<=0.
  - Next state is ON if count!=0, otherwise GAP.
- ON: timer increments each cycle. At timer==ON_TICKS-1: timer<=0, go to OFF.
- OFF:
  - Timer increments each cycle.
  - At timer==OFF_TICKS-1: timer<=0 and remaining<=remaining-1.
  - If remaining==1, go to GAP; otherwise go to ON.
- GAP: timer increments each cycle. At timer==GAP_TICKS-1: timer<=0, go to IDLE, and done<=1 for exactly that first IDLE cycle.
- Latency, with start accepted at edge t and N=count:
  - led_out rises at t+1.
  - Blink k (k=0..N-1) is high for cycles t+1+k*(ON_TICKS+OFF_TICKS) through t+k*(ON_TICKS+OFF_TICKS)+ON_TICKS.
  - busy is high for exactly N*(ON_TICKS+OFF_TICKS)+GAP_TICKS cycles.
  - done is high in the cycle immediately following the last busy cycle, with busy=0.
- start while busy=1 is ignored. The count is not re-captured and there is no queueing.
- start in the same cycle that done is high (IDLE) is accepted normally, giving back-to-back sequences.
- count changing after capture has no effect on the sequence in progress.
- count=0 produces no blinks: led_out stays 0 and busy is high for GAP_TICKS cycles, then done pulses.
- count=max (7 for CNT_W=3) produces 7 blinks; remaining never wraps because the decrement occurs only while remaining>=1.
- Timer and remaining arithmetic are unsigned. Compares are equality against parameter-1, sized to TMR_W.

Test Plan:
(Bench overrides ON_TICKS=3, OFF_TICKS=2, GAP_TICKS=4.)
- Reset: rst_n=1 for 2 cycles with start=1, count=5 -> busy=0, led_out=0, done=0; no sequence starts while in reset.
- count=2, start pulse at cycle 10 -> led_out=1 on cycles 11-13 and 16-18, 0 elsewhere; busy=1 on cycles 11-24; done=1 only on cycle 25.
- count=0, start at cycle 10 -> led_out never rises; busy=1 on cycles 11-14; done=1 on cycle 15.
- count=7 -> exactly 7 rising edges of led_out; busy width 7*5+4=39 cycles; one done pulse.
- count=3 start, then start with count=1 at busy cycles 2 and 8 -> both ignored, 3 blinks emitted. A start with count=1 in the done cycle -> accepted, 1 blink follows immediately.
- count=4 start, rst_n=1 on the 2nd ON cycle of blink 2 -> next cycle led_out=0, busy=0; done never asserts. A subsequent start with count=1 behaves normally.
